clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Runtime-programmable clock divider with a scheduler in front of it.
- Several requesters ask for a new divisor. A round-robin arbiter grants one request at a time.
- The granted divisor is applied only at a period boundary, so clk_out never has a runt pulse.
- Sits between the system clock source and the slow-clock consumers. It replaces fixed-factor division wherever the rate must change at runtime.

Parameters:
- NUM_REQ, 2: number of divisor requesters (2..8).
- DIV_W, 16: divisor width in bits.
- DEFAULT_DIV, 300: divisor loaded at reset. Must be >= 2 and < 2^DIV_W.

Ports:
- clk_in  input  1  source clock. All logic is on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NUM_REQ  per-requester divisor-change request. Level signal, held until gnt.
- div_in  input  NUM_REQ*DIV_W  requested divisors. Requester i uses bits [i*DIV_W +: DIV_W].
- gnt  output  NUM_REQ  one-cycle grant pulse, one-hot.
- err  output  1  one-cycle pulse, same cycle as gnt, when the granted divisor is < 2.
- busy  output  1  high while a granted divisor is pending.
- cur_div  output  DIV_W  divisor currently in force.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in every cycle where clk_out goes 0->1.

Behaviour:
- Reset values: cur_div=DEFAULT_DIV; cnt=0; clk_out=0; tick=0; gnt=0; err=0; busy=0; state=RUN; rr_last=NUM_REQ-1, so req[0] has highest priority first.
- Divider, with D=cur_div and H=floor(D/2):
  - cnt runs 0..D-1.
  - Edge with cnt==D-1: cnt<=0, clk_out<=1, tick<=1. This edge is the "boundary".
  - Edge with cnt==H-1: clk_out<=0.
  - Otherwise cnt increments.
- Resulting waveform: period is exactly D clk_in cycles, high for H cycles and low for D-H cycles. For odd D the low phase is the longer one.
- After reset release, the first clk_out rise occurs at the D-th rising edge of clk_in.
- State RUN:
  - If any req bit is high, select a winner round-robin, starting from rr_last+1 modulo NUM_REQ.
  - At the next edge: gnt[winner]<=1 for one cycle; rr_last<=winner; pend_div<=div_in of the winner.
  - If that divisor is >= 2: go to PEND with busy=1.
  - If it is < 2: err<=1 in the same cycle as gnt, pend_div is discarded, stay in RUN.
- State PEND:
  - No further grants are issued. Other requests keep waiting.
  - At the next boundary edge: cur_div<=pend_div, cnt<=0, clk_out<=1, tick<=1, busy<=0, go to RUN.
  - The new divisor governs the period that starts at that boundary.
- Grant edge coinciding with a boundary: that boundary still uses the old divisor. The new divisor is applied at the following boundary.
- Divisor equal to cur_div: processed normally. It passes through PEND with no visible waveform change.
- A req withdrawn before it is granted has no effect. Requesters must deassert req the cycle after gnt.
- At most one divisor change per clk_out period. A request arriving in PEND is granted at the earliest one cycle after the apply edge.
- rst asserted mid-operation: pending divisor discarded, all outputs return to reset values immediately, and the round-robin pointer resets.
- clk_out is glitch-free. It changes only from its own register, at most once per clk_in cycle.

Test Plan:
- Reset with DEFAULT_DIV=300, no requests -> first tick at cycle 300; then clk_out is high 150 cycles / low 150 cycles, and tick repeats every 300 cycles.
- req[0] with div=10 at cycle 20 -> gnt[0] at cycle 21, busy high; cur_div becomes 10 at the next boundary (cycle 300); the next tick is 10 cycles later, with high 5 / low 5.
- Divisor 2, then divisor 7 -> period 2 with 1 high / 1 low; then period 7 with 3 high / 4 low, and tick spacing exactly 7.
- req[0] and req[1] held together (div 4 and 6) -> gnt[0] first, gnt[1] only after the first apply edge; the next simultaneous pair grants req[1] first (round-robin).
- req[1] with div=1 -> gnt[1] and err pulse in the same cycle, busy stays 0, cur_div unchanged, period unchanged.
- rst pulsed while in PEND -> busy=0, cur_div=300, clk_out=0 immediately; the pending divisor is never applied; first tick at cycle 300 after release.

Source files
------------

// File: rtl/clk_div_sched.sv
// clk_div_sched: runtime-programmable clock divider. A round-robin
// scheduler accepts divisor requests and applies one per period.
// Ports: clk_in source clock; rst async active-high reset;
//   req/div_in per-requester divisor requests; gnt one-hot grant;
//   err grant of a divisor < 2; busy divisor pending; cur_div
//   divisor in force; clk_out divided clock; tick on clk_out rise.
module clk_div_sched #(
  parameter int NUM_REQ     = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 300
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] div_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     err,
  output logic                     busy,
  output logic [DIV_W-1:0]         cur_div,
  output logic                     clk_out,
  output logic                     tick
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO_D = DIV_W'(2);
  localparam logic [NUM_REQ-1:0] ONE_G = NUM_REQ'(1);
  localparam logic [IW:0] NR_W = (IW+1)'(NUM_REQ);

  typedef enum logic {RUN, PEND} state_t;

  state_t state;
  state_t state_d;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] win_div;
  logic [DIV_W-1:0] divs [NUM_REQ];
  logic [IW-1:0]    rr_last;
  logic [IW-1:0]    win;
  logic [IW:0]      idx;
  logic             bnd;
  logic             fall;
  logic             win_ok;
  logic             do_gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      divs[i] = div_in[i*DIV_W +: DIV_W];
    end
  end

  assign half = cur_div >> 1;
  assign bnd  = (cnt == cur_div - ONE_D);
  assign fall = (cnt == half - ONE_D);
  assign busy = (state == PEND);

  // Scan from farthest to nearest so the requester closest
  // after rr_last is the last, and winning, assignment.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, rr_last} + (IW+1)'(k);
      if (idx >= NR_W) idx = idx - NR_W;
      if (req[idx[IW-1:0]]) win = idx[IW-1:0];
    end
  end

  assign win_div = divs[win];
  assign win_ok  = (win_div >= TWO_D);

  always_comb begin
    state_d = state;
    do_gnt  = 1'b0;
    unique case (state)
      RUN: begin
        if (|req) begin
          do_gnt = 1'b1;
          if (win_ok) state_d = PEND;
        end
      end
      PEND: begin
        if (bnd) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      cur_div  <= DEF;
      pend_div <= DEF;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      gnt      <= '0;
      err      <= 1'b0;
      rr_last  <= IW'(NUM_REQ-1);
    end else begin
      state <= state_d;
      gnt   <= '0;
      err   <= 1'b0;
      tick  <= 1'b0;
      if (do_gnt) begin
        gnt     <= ONE_G << win;
        rr_last <= win;
        if (win_ok) pend_div <= win_div;
        else        err      <= 1'b1;
      end
      // A grant on this same edge only lands in pend_div, so the
      // boundary below still closes out the old period.
      if (bnd) begin
        cnt     <= '0;
        clk_out <= 1'b1;
        tick    <= 1'b1;
        if (state == PEND) cur_div <= pend_div;
      end else begin
        cnt <= cnt + ONE_D;
        if (fall) clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// tb_clk_div_sched: randomized scoreboard bench for clk_div_sched.
// A period-level reference model predicts every output cycle.
module tb_clk_div_sched;

  localparam int NR  = 3;
  localparam int DW  = 16;
  localparam int DEF = 300;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b0;
  logic [NR-1:0]    req    = '0;
  logic [NR*DW-1:0] div_in = '0;
  logic [NR-1:0]    gnt;
  logic             err;
  logic             busy;
  logic [DW-1:0]    cur_div;
  logic             clk_out;
  logic             tick;

  clk_div_sched #(
    .NUM_REQ(NR),
    .DIV_W(DW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .req(req),
    .div_in(div_in),
    .gnt(gnt),
    .err(err),
    .busy(busy),
    .cur_div(cur_div),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk_in or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int            n;
    logic [NR-1:0] gnt;
    logic          err;
    logic          busy;
    logic [DW-1:0] cur;
    logic          clk;
    logic          tick;
  } exp_t;

  exp_t sb[$];

  // Reference: periods as absolute boundary edge numbers.
  int m_n, m_cur, m_pend, m_next, m_blast, m_rr;

  always @(posedge clk_in) begin : model
    exp_t e;
    int   old_pend;
    int   w;
    int   d;
    bit   isb;
    if (rst) begin
      m_n     = 0;
      m_cur   = DEF;
      m_pend  = 0;
      m_next  = DEF;
      m_blast = -1;
      m_rr    = NR - 1;
      sb.delete();
    end else begin
      m_n      = m_n + 1;
      old_pend = m_pend;
      isb      = (m_n == m_next);
      e.gnt    = '0;
      e.err    = 1'b0;
      if (isb) begin
        if (old_pend != 0) begin
          m_cur  = old_pend;
          m_pend = 0;
        end
        m_blast = m_n;
        m_next  = m_n + m_cur;
      end
      if (old_pend == 0 && req != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          if (w < 0 && ((req >> ((m_rr + k) % NR)) & NR'(1)) != '0)
            w = (m_rr + k) % NR;
        end
        e.gnt = NR'(1) << w;
        m_rr  = w;
        d     = int'(DW'(div_in >> (w * DW)));
        if (d >= 2) m_pend = d;
        else        e.err  = 1'b1;
      end
      e.n    = m_n;
      e.busy = (m_pend != 0);
      e.cur  = DW'(m_cur);
      e.tick = isb;
      e.clk  = (m_blast >= 0) && ((m_n - m_blast) < (m_cur / 2));
      sb.push_back(e);
    end
  end

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst) begin
      n_cmp = n_cmp + 1;
      if (sb.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL sb_empty at cyc %0d: DUT output with no expectation", cyc);
      end else begin
        e = sb.pop_front();
        if (gnt !== e.gnt || err !== e.err || busy !== e.busy ||
            cur_div !== e.cur || clk_out !== e.clk || tick !== e.tick) begin
          n_bad = n_bad + 1;
          $display("FAIL out@%0d got gnt=%b err=%b busy=%b cur=%0d clk=%b tick=%b want gnt=%b err=%b busy=%b cur=%0d clk=%b tick=%b",
                   e.n, gnt, err, busy, cur_div, clk_out, tick,
                   e.gnt, e.err, e.busy, e.cur, e.clk, e.tick);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    #1;
    req = req & ~gnt;
  endtask

  task automatic post(input int i, input int d);
    logic [NR*DW-1:0] m;
    logic [NR*DW-1:0] v;
    m = '0;
    m[DW-1:0] = '1;
    v = '0;
    v[DW-1:0] = DW'(d);
    div_in = (div_in & ~(m << (i * DW))) | (v << (i * DW));
    req = req | (NR'(1) << i);
  endtask

  task automatic wait_tick(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (tick) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input int budget, output logic [NR-1:0] g,
                          output int at);
    at = -1;
    g = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      #1;
      if (gnt != '0) begin
        g = gnt;
        at = cyc;
        req = req & ~gnt;
        break;
      end
      req = req & ~gnt;
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check(nm, 64'(ok), 64'd1);
  endtask

  task automatic rst_assert();
    rst = 1'b1;
    req = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cur", 64'(cur_div), 64'(DEF));
    check("rst_clk", 64'(clk_out), 64'd0);
    check("rst_tick", 64'(tick), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk_in);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] g;
    int at;
    int t0;
    int t1;

    #2;
    rst_assert();

    while (cyc < 20) step();
    post(0, 10);
    wait_gnt(10, g, at);
    check("t2_gnt", 64'(g), 64'b001);
    check("t2_gnt_cyc", 64'(at), 64'd21);
    check("t2_busy", 64'(busy), 64'd1);
    wait_tick(400, at);
    check("t1_first_tick", 64'(at), 64'd300);
    check("t2_cur", 64'(cur_div), 64'd10);
    wait_tick(40, at);
    check("t2_next_tick", 64'(at), 64'd310);

    post(0, 2);
    wait_gnt(10, g, at);
    wait_idle("t3_idle2", 40);
    repeat (6) step();
    post(0, 7);
    wait_gnt(10, g, at);
    wait_idle("t3_idle7", 40);
    wait_tick(40, t0);
    wait_tick(40, t1);
    check("t3_period7", 64'(t1 - t0), 64'd7);

    post(1, 1);
    wait_gnt(10, g, at);
    check("t5_gnt", 64'(g), 64'b010);
    check("t5_err", 64'(err), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cur", 64'(cur_div), 64'd7);
    wait_tick(40, t0);
    wait_tick(40, t1);
    check("t5_period", 64'(t1 - t0), 64'd7);

    post(0, 4);
    post(1, 6);
    wait_gnt(10, g, at);
    check("t4_first", 64'(g), 64'b001);
    wait_gnt(40, g, at);
    check("t4_second", 64'(g), 64'b010);
    wait_idle("t4_idle", 40);

    post(0, 5);
    wait_gnt(10, g, at);
    wait_idle("t4_solo_idle", 40);
    post(0, 4);
    post(1, 6);
    wait_gnt(10, g, at);
    check("t4_rr_first", 64'(g), 64'b010);
    wait_gnt(40, g, at);
    check("t4_rr_second", 64'(g), 64'b001);
    wait_idle("t4_rr_idle", 40);

    for (int c = 0; c < 2500; c++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (((req >> i) & NR'(1)) == '0 && ((gnt >> i) & NR'(1)) == '0) begin
          if ($urandom_range(0, 15) == 0) post(i, int'($urandom_range(0, 12)));
        end else if (((req >> i) & NR'(1)) != '0) begin
          if ($urandom_range(0, 63) == 0) req = req & ~(NR'(1) << i);
        end
      end
    end
    req = '0;
    repeat (2) step();
    wait_idle("rand_idle", 40);

    post(0, 5);
    wait_gnt(10, g, at);
    check("t6_gnt", 64'(g), 64'b001);
    check("t6_busy", 64'(busy), 64'd1);
    rst_assert();
    wait_tick(400, at);
    check("t6_first_tick", 64'(at), 64'd300);
    check("t6_cur", 64'(cur_div), 64'(DEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
